pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and flush controller for the RISC-V pipeline, replacing separate load-use detection, forwarding selection and branch-flush glue with one stateful block. It keeps its own scoreboard of in-flight instructions from EX onward. The scoreboard supports a configurable number of forwarding stages, a configurable load latency and a data-memory ready handshake that freezes the pipeline. It also keeps stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/fwd_match.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared scoreboard entry type and constants for the hazard controller
package pipe_ctrl_pkg;

    localparam int RF_W_MAX = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [RF_W_MAX-1:0] rd;
        logic [RF_W_MAX-1:0] rs1;
        logic [RF_W_MAX-1:0] rs2;
        logic                regwrite;
        logic                memread;
        logic                memwrite;
    } inflight_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - priority matcher returning the lowest scoreboard index producing a register
module fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int N         = 3,
    parameter int LO        = 1,
    parameter int HI        = 2,
    parameter int IDX_W     = 2,
    parameter bit NEED_LOAD = 1'b0
) (
    input  inflight_t [N-1:0]    entries,
    input  logic [RF_W_MAX-1:0]  reg_addr,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    logic unused_entries;
    assign unused_entries = ^entries;

    // Walk from the far end so the youngest (lowest-index) producer wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = HI; k >= LO; k--) begin
            if (entries[k].valid && entries[k].regwrite && (entries[k].rd != '0) &&
                (entries[k].rd == reg_addr) && (!NEED_LOAD || entries[k].memread)) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - scoreboard-based forwarding, load-use stall, memory freeze and flush control
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RF_ADDRESS = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  ex_redirect,
    input  logic                  dmem_ready,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  freeze,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int NE = FWD_DEPTH + 1;

    inflight_t [NE-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [RF_W_MAX-1:0] id_rs1_x, id_rs2_x;
    logic                hit_a, hit_b, hit_lu1, hit_lu2;
    logic [SEL_W-1:0]    idx_a, idx_b, lu1_idx_unused, lu2_idx_unused;
    logic                load_use, redirect_apply, luse_apply;
    inflight_t           id_entry;

    assign id_rs1_x = RF_W_MAX'(id_rs1);
    assign id_rs2_x = RF_W_MAX'(id_rs2);

    fwd_match #(.N(NE), .LO(1), .HI(FWD_DEPTH), .IDX_W(SEL_W), .NEED_LOAD(1'b0)) u_fwd_a (
        .entries(sb_q), .reg_addr(sb_q[0].rs1), .hit(hit_a), .idx(idx_a)
    );
    fwd_match #(.N(NE), .LO(1), .HI(FWD_DEPTH), .IDX_W(SEL_W), .NEED_LOAD(1'b0)) u_fwd_b (
        .entries(sb_q), .reg_addr(sb_q[0].rs2), .hit(hit_b), .idx(idx_b)
    );
    fwd_match #(.N(NE), .LO(0), .HI(LOAD_LAT - 1), .IDX_W(SEL_W), .NEED_LOAD(1'b1)) u_lu_rs1 (
        .entries(sb_q), .reg_addr(id_rs1_x), .hit(hit_lu1), .idx(lu1_idx_unused)
    );
    fwd_match #(.N(NE), .LO(0), .HI(LOAD_LAT - 1), .IDX_W(SEL_W), .NEED_LOAD(1'b1)) u_lu_rs2 (
        .entries(sb_q), .reg_addr(id_rs2_x), .hit(hit_lu2), .idx(lu2_idx_unused)
    );

    // Freeze dominates, then redirect, then load-use; a frozen redirect waits because ex_redirect stays high.
    always_comb begin
        freeze         = sb_q[1].valid && (sb_q[1].memread || sb_q[1].memwrite) && !dmem_ready;
        load_use       = id_valid && (hit_lu1 || hit_lu2);
        redirect_apply = ex_redirect && !freeze;
        luse_apply     = load_use && !freeze && !ex_redirect;

        stall_pc     = luse_apply;
        stall_if_id  = luse_apply;
        bubble_id_ex = redirect_apply || luse_apply;
        flush_if_id  = redirect_apply;

        fwd_a_sel = (sb_q[0].valid && hit_a) ? idx_a : SEL_W'(FWD_RF);
        fwd_b_sel = (sb_q[0].valid && hit_b) ? idx_b : SEL_W'(FWD_RF);

        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.rd       = RF_W_MAX'(id_rd);
        id_entry.rs1      = id_rs1_x;
        id_entry.rs2      = id_rs2_x;
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
        id_entry.memwrite = id_memwrite;

        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze) begin
            for (int k = NE - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = (redirect_apply || luse_apply) ? '0 : id_entry;
        end
        if (freeze || luse_apply) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_apply) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regwrite, id_memread, id_memwrite;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, dmem_ready;

    logic        s_pc1, s_ifid1, bub1, fl1, frz1;
    logic [1:0]  fa1, fb1;
    logic [31:0] scnt1, fcnt1;
    logic        s_pc2, s_ifid2, bub2, fl2, frz2;
    logic [1:0]  fa2, fb2;
    logic [31:0] scnt2, fcnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .stall_pc(s_pc1), .stall_if_id(s_ifid1), .bubble_id_ex(bub1), .flush_if_id(fl1),
        .freeze(frz1), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .stall_pc(s_pc2), .stall_if_id(s_ifid2), .bubble_id_ex(bub2), .flush_if_id(fl2),
        .freeze(frz2), .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = d;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    endtask

    task automatic idle;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        reset = 1'b1; ex_redirect = 1'b0; dmem_ready = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({s_pc1, s_ifid1, bub1, fl1, frz1}), 32'd0);
        chk({tag, "_fwd"}, 32'({fa1, fb1}), 32'd0);
        chk({tag, "_scnt"}, scnt1, 32'd0);
        chk({tag, "_fcnt"}, fcnt1, 32'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        #2;
        chk_all_zero("reset");

        // add x5 ; sub x8,x5,x3 -> forward from MEM
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd3, 5'd8, 1, 0, 0); #2;
        chk("fwd_add_in_ex", 32'(fa1), 32'd0);
        tick(); idle(); #2;
        chk("fwd_mem_a", 32'(fa1), 32'd1);
        chk("fwd_mem_b", 32'(fb1), 32'd0);

        // add x5 ; add x9 ; sub x8,x5,x3 -> forward from WB
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd3, 5'd8, 1, 0, 0); tick();
        idle(); #2;
        chk("fwd_wb_a", 32'(fa1), 32'd2);

        // two producers of x5 in flight: nearest wins; operand b also hits
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd5, 5'd5, 5'd8, 1, 0, 0); tick();
        idle(); #2;
        chk("fwd_prio_a", 32'(fa1), 32'd1);
        chk("fwd_prio_b", 32'(fb1), 32'd1);

        // lw x6 ; add x7,x6,x1 with LOAD_LAT=1
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 0); tick();
        drive(1, 5'd6, 5'd1, 5'd7, 1, 0, 0); #2;
        chk("lu1_stall", 32'({s_pc1, s_ifid1, bub1, fl1}), 32'b1110);
        tick(); #2;
        chk("lu1_release", 32'(s_pc1), 32'd0);
        chk("lu1_scnt", scnt1, 32'd1);
        tick(); idle(); #2;
        chk("lu1_fwd", 32'(fa1), 32'd2);

        // lw x6 ; add x7,x6,x1 with LOAD_LAT=2, FWD_DEPTH=3
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 0); tick();
        drive(1, 5'd6, 5'd1, 5'd7, 1, 0, 0); #2;
        chk("lu2_stall0", 32'({s_pc2, s_ifid2, bub2}), 32'b111);
        tick(); #2;
        chk("lu2_stall1", 32'({s_pc2, s_ifid2, bub2}), 32'b111);
        tick(); #2;
        chk("lu2_release", 32'(s_pc2), 32'd0);
        chk("lu2_scnt", scnt2, 32'd2);
        tick(); idle(); #2;
        chk("lu2_fwd", 32'(fa2), 32'd3);

        // add x5 ; lw x6 ; sub x8,x5,x3 then dmem_ready low for 3 cycles
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); tick();
        drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 0); tick();
        drive(1, 5'd5, 5'd3, 5'd8, 1, 0, 0); tick();
        idle(); dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("frz_on%0d", i), 32'(frz1), 32'd1);
            chk($sformatf("frz_ctl%0d", i), 32'({s_pc1, s_ifid1, bub1, fl1}), 32'd0);
            chk($sformatf("frz_fwd%0d", i), 32'(fa1), 32'd2);
            tick();
        end
        dmem_ready = 1'b1; #2;
        chk("frz_release", 32'(frz1), 32'd0);
        chk("frz_scnt", scnt1, 32'd3);
        chk("frz_held_fwd", 32'(fa1), 32'd2);
        tick(); #2;
        chk("frz_advanced", 32'(fa1), 32'd0);

        // redirect arriving during a 2-cycle freeze
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 0); tick();
        drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 0); tick();
        drive(1, 5'd3, 5'd4, 5'd10, 1, 0, 0);
        dmem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk($sformatf("rd_frz%0d", i), 32'({frz1, fl1, bub1}), 32'b100);
            chk($sformatf("rd_fcnt%0d", i), fcnt1, 32'd0);
            tick();
        end
        dmem_ready = 1'b1; #2;
        chk("rd_apply", 32'({frz1, fl1, bub1, s_pc1}), 32'b0110);
        tick(); ex_redirect = 1'b0; idle(); #2;
        chk("rd_fcnt", fcnt1, 32'd1);
        chk("rd_scnt", scnt1, 32'd2);

        // x0 destinations never forward or stall
        do_reset();
        drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd8, 1, 0, 0); tick();
        idle(); #2;
        chk("x0_fwd", 32'({fa1, fb1}), 32'd0);
        drive(1, 5'd1, 5'd0, 5'd0, 1, 1, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd7, 1, 0, 0); #2;
        chk("x0_no_stall", 32'({s_pc1, bub1}), 32'd0);

        // reset while frozen
        do_reset();
        drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 0); tick();
        idle(); tick();
        dmem_ready = 1'b0; #2;
        chk("rst_frz_pre", 32'(frz1), 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; #2;
        chk_all_zero("rst_frz");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
